// File: rtl/io_responder.sv
// rtl/io_responder.sv - IN/OUT board responder: debounced button + switch capture, OUT latch, hex display
module io_responder #(
    parameter int DATA_W       = 32,
    parameter int SW_W         = 16,
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              botao,
    input  logic [SW_W-1:0]   chaves,
    input  logic              in_req,
    output logic              enter,
    output logic [DATA_W-1:0] dado_in,
    input  logic              out_strobe,
    input  logic [DATA_W-1:0] out_data,
    output logic [DATA_W-1:0] dado_out,
    output logic              out_valid,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex3
);

    localparam int               CNT_W   = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEB,
        S_PEND,
        S_ACK,
        S_REL
    } state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             enter_next;
    logic             capture;
    logic             sync_q, b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            b      <= 1'b0;
        end else begin
            sync_q <= botao;
            b      <= sync_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
            cnt   <= '0;
            enter <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            enter <= enter_next;
        end
    end

    // Counter restarts on every state change so each stable window is measured from zero.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        enter_next = enter;
        capture    = 1'b0;
        case (state)
            S_IDLE: begin
                if (b) begin
                    state_next = S_DEB;
                    cnt_next   = '0;
                end
            end
            S_DEB: begin
                if (!b) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = S_PEND;
                    cnt_next   = '0;
                    capture    = 1'b1;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            S_PEND: begin
                if (in_req) begin
                    state_next = S_ACK;
                    cnt_next   = '0;
                    enter_next = 1'b1;
                end
            end
            S_ACK: begin
                if (!in_req) begin
                    state_next = S_REL;
                    cnt_next   = '0;
                    enter_next = 1'b0;
                end
            end
            S_REL: begin
                if (b) begin
                    cnt_next = '0;
                end else if (cnt == CNT_MAX) begin
                    state_next = S_IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
                enter_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dado_in <= '0;
        end else if (capture) begin
            dado_in <= DATA_W'(chaves);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dado_out  <= '0;
            out_valid <= 1'b0;
        end else if (out_strobe) begin
            dado_out  <= out_data;
            out_valid <= 1'b1;
        end
    end

    // Active-low segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'b1000000;
            4'h1: seg7 = 7'b1111001;
            4'h2: seg7 = 7'b0100100;
            4'h3: seg7 = 7'b0110000;
            4'h4: seg7 = 7'b0011001;
            4'h5: seg7 = 7'b0010010;
            4'h6: seg7 = 7'b0000010;
            4'h7: seg7 = 7'b1111000;
            4'h8: seg7 = 7'b0000000;
            4'h9: seg7 = 7'b0010000;
            4'hA: seg7 = 7'b0001000;
            4'hB: seg7 = 7'b0000011;
            4'hC: seg7 = 7'b1000110;
            4'hD: seg7 = 7'b0100001;
            4'hE: seg7 = 7'b0000110;
            default: seg7 = 7'b0001110;
        endcase
    endfunction

    assign hex0 = seg7(dado_out[3:0]);
    assign hex1 = seg7(dado_out[7:4]);
    assign hex2 = seg7(dado_out[11:8]);
    assign hex3 = seg7(dado_out[15:12]);

endmodule

// File: tb/tb_io_responder.sv
// tb/tb_io_responder.sv - scoreboard bench for io_responder with randomized presses and OUT writes
module tb_io_responder;

    localparam int DC = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        botao;
    logic [15:0] chaves;
    logic        in_req;
    logic        enter;
    logic [31:0] dado_in;
    logic        out_strobe;
    logic [31:0] out_data;
    logic [31:0] dado_out;
    logic        out_valid;
    logic [6:0]  hex0, hex1, hex2, hex3;

    io_responder #(.DATA_W(32), .SW_W(16), .DEBOUNCE_CYC(DC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .botao     (botao),
        .chaves    (chaves),
        .in_req    (in_req),
        .enter     (enter),
        .dado_in   (dado_in),
        .out_strobe(out_strobe),
        .out_data  (out_data),
        .dado_out  (dado_out),
        .out_valid (out_valid),
        .hex0      (hex0),
        .hex1      (hex1),
        .hex2      (hex2),
        .hex3      (hex3)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_q [$];
    logic [31:0] m_dout;
    logic        m_valid;
    logic        prev_en = 1'b0;
    logic        stim_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int h);
        botao = 1'b1;
        tick(h);
        botao = 1'b0;
    endtask

    task automatic wait_en(input logic lvl, input int bound);
        int n;
        n = 0;
        while (enter !== lvl && n < bound) begin
            tick(1);
            n++;
        end
        chk("enter_wait", 32'(enter), 32'(lvl));
    endtask

    // Reference for the OUT path: last strobed word, sticky valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_dout  <= '0;
            m_valid <= 1'b0;
        end else if (out_strobe) begin
            m_dout  <= out_data;
            m_valid <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en = 1'b0;
        end else begin
            if (enter && !prev_en) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_enter actual=1 expected=0 at %0t", $time);
                end else begin
                    chk("enter_word", dado_in, exp_q.pop_front());
                end
            end
            prev_en = enter;
            chk("dado_out", dado_out, m_dout);
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("hex", 32'({hex3, hex2, hex1, hex0}),
                32'({GLYPH[m_dout[15:12]], GLYPH[m_dout[11:8]], GLYPH[m_dout[7:4]], GLYPH[m_dout[3:0]]}));
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; botao = 1'b0; chaves = '0; in_req = 1'b0;
        out_strobe = 1'b0; out_data = '0;
        tick(3);
        rst_n = 1'b1;
        tick(1);
        chk("rst_enter", 32'(enter), 32'h0);
        chk("rst_dado_in", dado_in, 32'h0);
        chk("rst_dado_out", dado_out, 32'h0);
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_hex", 32'({hex3, hex2, hex1, hex0}), 32'({7'h40, 7'h40, 7'h40, 7'h40}));

        // Press with in_req already high: 2 sync + 1 to DEB + 4 counting + 1 to enter.
        chaves = 16'h00A5; in_req = 1'b1;
        exp_q.push_back(32'h000000A5);
        botao = 1'b1;
        tick(7);
        chk("t1_enter_early", 32'(enter), 32'h0);
        tick(1);
        chk("t1_enter_lat", 32'(enter), 32'h1);
        chk("t1_dado_in", dado_in, 32'h000000A5);
        tick(2);
        botao = 1'b0; in_req = 1'b0;
        tick(1);
        chk("t1_enter_drop", 32'(enter), 32'h0);
        tick(DC + 6);

        // Word pending before in_req; later switch changes must not leak in.
        chaves = 16'h1234;
        exp_q.push_back(32'h00001234);
        press(10);
        chaves = 16'hFFFF;
        tick(20);
        chk("t2_pending_no_enter", 32'(enter), 32'h0);
        in_req = 1'b1;
        tick(1);
        chk("t2_enter_lat", 32'(enter), 32'h1);
        chk("t2_dado_in", dado_in, 32'h00001234);
        in_req = 1'b0;
        tick(1);
        chk("t2_enter_drop", 32'(enter), 32'h0);
        tick(DC + 6);

        // Short glitch is rejected.
        in_req = 1'b1;
        press(3);
        tick(20);
        chk("t3_no_enter", 32'(enter), 32'h0);
        chk("t3_dado_in", dado_in, 32'h00001234);
        in_req = 1'b0;
        tick(2);

        // Long hold across two in_req windows gives one word only.
        chaves = 16'h4321; in_req = 1'b1;
        exp_q.push_back(32'h00004321);
        botao = 1'b1;
        tick(20);
        in_req = 1'b0;
        tick(10);
        in_req = 1'b1;
        tick(20);
        chk("t4_no_refire", 32'(enter), 32'h0);
        botao = 1'b0;
        tick(DC + 6);
        chk("t4_no_enter_after_release", 32'(enter), 32'h0);
        chaves = 16'h5A5A;
        exp_q.push_back(32'h00005A5A);
        press(10);
        wait_en(1'b1, 10);
        in_req = 1'b0;
        tick(DC + 8);

        // OUT write and display.
        out_strobe = 1'b1; out_data = 32'hDEADBEEF;
        tick(1);
        out_strobe = 1'b0;
        chk("t5_dado_out", dado_out, 32'hDEADBEEF);
        chk("t5_out_valid", 32'(out_valid), 32'h1);
        chk("t5_hex0", 32'(hex0), 32'(7'b0001110));
        chk("t5_hex3_1", 32'({hex3, hex2, hex1}), 32'({7'b0000011, 7'b0000110, 7'b0000110}));
        tick(2);

        // Randomized presses with concurrent random OUT writes.
        fork
            begin
                while (!stim_done) begin
                    out_strobe = 1'($urandom_range(0, 1));
                    out_data   = $urandom;
                    @(posedge clk);
                    #1;
                end
                out_strobe = 1'b0;
            end
            begin
                for (int i = 0; i < 30; i++) begin
                    logic ir, acc;
                    int   h;
                    chaves = 16'($urandom);
                    ir     = 1'($urandom_range(0, 1));
                    acc    = ($urandom_range(0, 2) != 0);
                    h      = acc ? $urandom_range(DC + 4, 3 * DC + 8) : $urandom_range(1, DC - 1);
                    in_req = ir;
                    if (acc) exp_q.push_back({16'h0, chaves});
                    press(h);
                    chaves = 16'($urandom);
                    if (acc) begin
                        if (!ir) begin
                            tick($urandom_range(0, 10));
                            chk("rnd_pend_no_enter", 32'(enter), 32'h0);
                            in_req = 1'b1;
                            tick(1);
                            chk("rnd_req_lat", 32'(enter), 32'h1);
                        end else begin
                            wait_en(1'b1, 3 * DC);
                        end
                        in_req = 1'b0;
                        tick(1);
                        chk("rnd_enter_drop", 32'(enter), 32'h0);
                    end else begin
                        tick(2);
                        in_req = 1'b0;
                    end
                    tick(DC + 8);
                end
                stim_done = 1'b1;
            end
        join
        tick(2);

        // Reset in the middle of a handshake.
        chaves = 16'h7777; in_req = 1'b1;
        exp_q.push_back(32'h00007777);
        press(10);
        chk("t6_enter_before", 32'(enter), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_enter", 32'(enter), 32'h0);
        chk("t6_rst_dado_in", dado_in, 32'h0);
        chk("t6_rst_dado_out", dado_out, 32'h0);
        chk("t6_rst_out_valid", 32'(out_valid), 32'h0);
        tick(2);
        rst_n = 1'b1;
        tick(20);
        chk("t6_idle_after_rst", 32'(enter), 32'h0);
        chaves = 16'h8888;
        exp_q.push_back(32'h00008888);
        press(10);
        wait_en(1'b1, 10);
        in_req = 1'b0;
        tick(DC + 8);

        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
